// File: rtl/fp_result_credit_buffer.sv
// Result FIFO behind the fixed-latency FP formula pipeline. It hands out issue credits
// so that results already in flight always have a free slot waiting for them.
module fp_result_credit_buffer #(
  parameter int FLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int PIPE_LAT = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_fire,
  output logic                         issue_rdy,
  input  logic                         pipe_vld,
  input  logic [FLEN-1:0]              pipe_res,
  output logic                         res_vld,
  input  logic                         res_rdy,
  output logic [FLEN-1:0]              res,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   in_flight,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [FLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [FLEN-1:0] last_q, last_d;
  logic            ovf_q, ovf_d;

  logic [CW:0]     credit_sum;
  logic            empty, full;
  logic            pop, drop, wr_en;
  logic            accept, bad_issue;
  logic            underflow, ret;

  // A return with nothing outstanding is a protocol error; the count clamps at zero.
  function automatic logic [CW-1:0] infl_next(input logic [CW-1:0] cur,
                                              input logic inc, input logic dec);
    logic [CW-1:0] tmp;
    tmp = cur + CW'(inc);
    if (dec && tmp != '0) tmp = tmp - CW'(1);
    return tmp;
  endfunction

  always_comb begin
    credit_sum = {1'b0, occ_q} + {1'b0, infl_q};
    issue_rdy  = credit_sum < (CW+1)'(DEPTH);
    empty      = (occ_q == '0);
    full       = (occ_q == CW'(DEPTH));
    pop        = !empty && res_rdy;
    drop       = pipe_vld && full && !pop;
    wr_en      = pipe_vld && !drop;
    accept     = issue_fire && issue_rdy;
    bad_issue  = issue_fire && !issue_rdy;
    underflow  = pipe_vld && (infl_q == '0);
    ret        = pipe_vld && !underflow;

    infl_d   = infl_next(infl_q, accept, ret);
    occ_d    = occ_q + CW'(wr_en) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    ovf_d    = ovf_q | drop | underflow | bad_issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array carries no reset; only slots covered by occupancy are ever shown.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pipe_res;
  end

  // With the FIFO empty the last popped word stays on res.
  assign res_vld   = !empty;
  assign res       = empty ? last_q : mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign in_flight = infl_q;
  assign overflow  = ovf_q;

  a_no_full_drop: assert property (@(posedge clk) disable iff (!rst)
    !(pipe_vld && full && !pop));
  a_infl_bound: assert property (@(posedge clk) disable iff (!rst)
    infl_q <= CW'(PIPE_LAT));

endmodule

// File: tb/tb_fp_result_credit_buffer.sv
// Scoreboard bench for fp_result_credit_buffer with a fixed-latency pipeline model.
module tb_fp_result_credit_buffer;
  localparam int FLEN  = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 12;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            issue_fire = 1'b0;
  logic            pipe_vld = 1'b0;
  logic            res_rdy = 1'b0;
  logic [FLEN-1:0] pipe_res = '0;
  logic            issue_rdy, res_vld, overflow;
  logic [FLEN-1:0] res;
  logic [CW-1:0]   occupancy, in_flight;

  always #5 clk = ~clk;

  fp_result_credit_buffer #(.FLEN(FLEN), .DEPTH(DEPTH), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .issue_fire(issue_fire), .issue_rdy(issue_rdy),
    .pipe_vld(pipe_vld), .pipe_res(pipe_res), .res_vld(res_vld), .res_rdy(res_rdy),
    .res(res), .occupancy(occupancy), .in_flight(in_flight), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic        sv [2048];
  logic [31:0] sd [2048];
  logic [31:0] exp_q [$];
  int next_idx, n_acc, acc_at_drop, first_pv, first_rv, first_pop, last_pop, npop;
  bit rdy_low;
  bit hold_pend = 1'b0;
  logic [31:0] hold_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Integer n (1..1023) encoded as an IEEE single.
  function automatic logic [31:0] fp_of_int(input int n);
    int e;
    logic [31:0] m;
    e = 0;
    while ((n >> (e+1)) != 0) e++;
    m = 32'(n - (1 << e)) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic clear_trk();
    n_acc = 0; acc_at_drop = -1; rdy_low = 1'b0;
    first_pv = -1; first_rv = -1; first_pop = -1; last_pop = -1; npop = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; issue_fire = 1'b0; pipe_vld = 1'b0; res_rdy = 1'b0;
    exp_q.delete();
    foreach (sv[i]) begin sv[i] = 1'b0; sd[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One clock: top-level arg_rdy gating plus the fixed-latency pipeline model.
  task automatic cycle(input bit want, input bit rdy, input bit frc);
    res_rdy  = rdy;
    pipe_vld = sv[cyc];
    pipe_res = sd[cyc];
    if (!issue_rdy) rdy_low = 1'b1;
    if (!issue_rdy && acc_at_drop < 0) acc_at_drop = n_acc;
    issue_fire = frc | (want & issue_rdy);
    if (issue_fire && issue_rdy) begin
      sv[cyc+LAT] = 1'b1;
      sd[cyc+LAT] = fp_of_int(next_idx);
      exp_q.push_back(fp_of_int(next_idx));
      next_idx++;
      n_acc++;
    end
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic force_push(input logic [31:0] v);
    sv[cyc] = 1'b1;
    sd[cyc] = v;
    exp_q.push_back(v);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || in_flight != 0); k++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_vld", 32'(res_vld), 32'd1);
        chk("hold_res", res, hold_val);
      end
      if (pipe_vld && first_pv < 0) first_pv = cyc;
      if (res_vld && first_rv < 0) first_rv = cyc;
      if (res_vld && res_rdy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected: got %0h expected no output", res);
        end else begin
          chk("order", res, exp_q.pop_front());
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
      hold_pend = res_vld && !res_rdy;
      hold_val  = res;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_trk();
    do_reset();
    chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
    chk("rst_res_vld",   32'(res_vld),   32'd0);
    chk("rst_res",       res,            32'd0);
    chk("rst_occ",       32'(occupancy), 32'd0);
    chk("rst_infl",      32'(in_flight), 32'd0);
    chk("rst_ovf",       32'(overflow),  32'd0);

    // 20 back-to-back issues, 1.0 .. 20.0, consumer always ready
    clear_trk();
    next_idx = 1;
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    drain(60);
    chk("t2_drained",   32'(exp_q.size()), 32'd0);
    chk("t2_npop",      32'(npop), 32'd20);
    chk("t2_first_lat", 32'(first_rv - first_pv), 32'd1);
    chk("t2_no_gap",    32'(last_pop - first_pop), 32'd19);
    chk("t2_rdy_high",  32'(rdy_low), 32'd0);
    chk("t2_ovf",       32'(overflow), 32'd0);

    // stalled consumer: credits run out at exactly DEPTH
    do_reset();
    clear_trk();
    next_idx = 101;
    repeat (40) cycle(1'b1, 1'b0, 1'b0);
    chk("t3_acc_at_drop", 32'(acc_at_drop), 32'd16);
    chk("t3_acc_total",   32'(n_acc), 32'd16);
    chk("t3_occ_full",    32'(occupancy), 32'd16);
    chk("t3_infl",        32'(in_flight), 32'd0);
    chk("t3_rdy_low",     32'(issue_rdy), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t3_rdy_back",    32'(issue_rdy), 32'd1);
    drain(60);
    chk("t3_drained",     32'(exp_q.size()), 32'd0);
    chk("t3_occ_empty",   32'(occupancy), 32'd0);

    // full FIFO, push and pop in the same cycle, then a wrapping random stream
    do_reset();
    clear_trk();
    next_idx = 201;
    repeat (40) cycle(1'b1, 1'b0, 1'b0);
    chk("t4_occ_full", 32'(occupancy), 32'd16);
    force_push(fp_of_int(100));
    cycle(1'b0, 1'b1, 1'b0);
    chk("t4_occ_stays", 32'(occupancy), 32'd16);
    chk("t4_head_adv",  res, fp_of_int(202));
    clear_trk();
    next_idx = 301;
    for (int k = 0; k < 600 && n_acc < 40; k++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0);
    chk("t4_stream_acc", 32'(n_acc), 32'd40);
    drain(200);
    chk("t4_drained",    32'(exp_q.size()), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);

    // protocol errors: return with nothing in flight
    do_reset();
    chk("t5_ovf_clear", 32'(overflow), 32'd0);
    clear_trk();
    force_push(fp_of_int(500));
    cycle(1'b0, 1'b0, 1'b0);
    chk("t5_underflow_ovf", 32'(overflow), 32'd1);
    chk("t5_infl_sat",      32'(in_flight), 32'd0);
    chk("t5_occ",           32'(occupancy), 32'd1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);
    chk("t5_drained",    32'(exp_q.size()), 32'd0);
    do_reset();
    chk("t5_ovf_rst", 32'(overflow), 32'd0);

    // protocol errors: issue without a credit
    clear_trk();
    next_idx = 401;
    repeat (16) cycle(1'b1, 1'b0, 1'b0);
    chk("t5_acc16",    32'(n_acc), 32'd16);
    chk("t5_no_cred",  32'(issue_rdy), 32'd0);
    chk("t5_ovf_pre",  32'(overflow), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("t5_bad_issue_ovf", 32'(overflow), 32'd1);
    chk("t5_not_counted",   32'(occupancy) + 32'(in_flight), 32'd16);

    // asynchronous reset with five entries stored
    do_reset();
    clear_trk();
    next_idx = 601;
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    repeat (15) cycle(1'b0, 1'b0, 1'b0);
    chk("t6_occ5", 32'(occupancy), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_vld", 32'(res_vld),   32'd0);
    chk("t6_async_occ", 32'(occupancy), 32'd0);
    chk("t6_async_rdy", 32'(issue_rdy), 32'd1);
    do_reset();
    clear_trk();
    next_idx = 701;
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    drain(60);
    chk("t6_restart_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_restart_npop",    32'(npop), 32'd3);
    chk("t6_restart_ovf",     32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
